// File: rtl/fir_serial_mac_if.sv
// Sample-in / coefficient-ROM / result-out bundle of the serial-MAC FIR engine.
// slave is the filter engine. master is the environment: sample source, coefficient ROM and result sink.
interface fir_serial_mac_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DW     = 16,
  parameter int unsigned CW     = 16
);
  logic [DW-1:0]     din;
  logic              din_valid;
  logic              din_ready;
  logic              mode_sel;
  logic              flush;
  logic [ADDR_W-1:0] coef_addr;
  logic              coef_mode;
  logic [CW-1:0]     coef_data;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              busy;

  modport slave (
    input  din, din_valid, mode_sel, flush, coef_data,
    output din_ready, coef_addr, coef_mode, dout, dout_valid, busy
  );

  modport master (
    output din, din_valid, mode_sel, flush, coef_data,
    input  din_ready, coef_addr, coef_mode, dout, dout_valid, busy
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Time-multiplexed 32-tap FIR: one multiply-accumulate per cycle against an external
// coefficient ROM, one rounded and saturated result per accepted sample.
module fir_serial_mac #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DW     = 16,
  parameter int unsigned CW     = 16,
  parameter int unsigned FRAC   = 15,
  parameter int unsigned ACC_W  = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_serial_mac_if.slave  bus
);

  localparam int unsigned NTAPS = 2 ** ADDR_W;
  localparam int unsigned PW    = DW + CW;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                  state_q, state_nxt;
  logic signed [DW-1:0]    x_q [NTAPS];
  logic signed [ACC_W-1:0] acc_q, acc_nxt;
  logic [ADDR_W-1:0]       k_q, k_nxt;
  logic                    mode_q, mode_nxt;
  logic [DW-1:0]           dout_q, dout_nxt;
  logic                    din_ready_q, busy_q, dout_valid_q;
  logic                    shift_c, clear_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [ACC_W-1:0] acc_sum_c, rnd_c;
  logic [DW-1:0]           sat_c;

  // Datapath: full-precision product, accumulate, then round-half-up and saturate
  assign prod_c    = x_q[k_q] * $signed(bus.coef_data);
  assign acc_sum_c = acc_q + ACC_W'(prod_c);
  assign rnd_c     = (acc_sum_c + RND) >>> FRAC;

  always_comb begin
    sat_c = rnd_c[DW-1:0];
    if (!((rnd_c[ACC_W-1:DW-1] == '0) || (rnd_c[ACC_W-1:DW-1] == '1))) begin
      sat_c = rnd_c[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Result is formed on the final MAC edge so dout and dout_valid appear together in DONE
  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    acc_nxt   = acc_q;
    mode_nxt  = mode_q;
    dout_nxt  = dout_q;
    shift_c   = 1'b0;
    clear_c   = 1'b0;
    case (state_q)
      IDLE: begin
        clear_c = bus.flush;
        if (bus.din_valid) begin
          shift_c   = 1'b1;
          mode_nxt  = bus.mode_sel;
          acc_nxt   = '0;
          k_nxt     = '0;
          state_nxt = MAC;
        end
      end
      MAC: begin
        acc_nxt = acc_sum_c;
        k_nxt   = k_q + 1'b1;
        if (k_q == LAST_K) begin
          dout_nxt  = sat_c;
          state_nxt = DONE;
        end
      end
      DONE: begin
        k_nxt     = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      k_q          <= '0;
      mode_q       <= 1'b0;
      dout_q       <= '0;
      din_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      acc_q        <= acc_nxt;
      k_q          <= k_nxt;
      mode_q       <= mode_nxt;
      dout_q       <= dout_nxt;
      din_ready_q  <= (state_nxt == IDLE);
      busy_q       <= (state_nxt != IDLE);
      dout_valid_q <= (state_nxt == DONE);
    end
  end

  // Delay line; a flush coinciding with an accept clears the old samples before the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (shift_c) begin
      x_q[0] <= bus.din;
      for (int unsigned i = 1; i < NTAPS; i++) x_q[i] <= clear_c ? '0 : x_q[i-1];
    end else if (clear_c) begin
      for (int unsigned i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.busy       = busy_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.coef_addr  = k_q;
  assign bus.coef_mode  = mode_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: stub coefficient ROM, scoreboard queue of
// hand-computed results, monitor popping on every dout_valid.
module tb_fir_serial_mac;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_serial_mac_if bus ();

  fir_serial_mac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] rom_lp [32];
  logic [15:0] rom_hp [32];
  assign bus.coef_data = bus.coef_mode ? rom_hp[bus.coef_addr] : rom_lp[bus.coef_addr];

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every result strobe must match the oldest pending expectation
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_dout: got %h with no result pending at %0t", bus.dout, $time);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(bus.dout), 32'(e));
        end
      end
    end
  end

  task automatic set_rom(input logic [15:0] lp, input logic [15:0] hp);
    for (int i = 0; i < 32; i++) begin
      rom_lp[i] = lp;
      rom_hp[i] = hp;
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: din_ready still %b after %0d cycles", bus.din_ready, t);
    end
  endtask

  // Present a sample and return just after the accepting clock edge
  task automatic accept(input logic [15:0] s, input logic m, input logic f,
                        input logic [15:0] e, input bit want);
    @(negedge clk);
    bus.din       = s;
    bus.din_valid = 1'b1;
    bus.mode_sel  = m;
    bus.flush     = f;
    wait_ready();
    if (want) exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic send(input logic [15:0] s, input logic m, input logic f, input logic [15:0] e);
    accept(s, m, f, e, 1'b1);
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    int t;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.mode_sel  = 1'b0;
    bus.flush     = 1'b0;
    set_rom(16'h4000, 16'h2000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    check("rst_din_ready", 32'(bus.din_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_coef_addr", 32'(bus.coef_addr), 32'd0);
    check("rst_coef_mode", 32'(bus.coef_mode), 32'd0);

    // Impulse: 0x7FFF then 32 zeros against h = 0x4000
    send(16'h7FFF, 1'b0, 1'b0, 16'h4000);
    for (int n = 2; n <= 33; n++) send(16'h0000, 1'b0, 1'b0, (n == 33) ? 16'h0000 : 16'h4000);

    // Timing and addressing with din_valid held high
    accept(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      check("t_din_ready_low", 32'(bus.din_ready), 32'd0);
      check("t_busy", 32'(bus.busy), 32'd1);
      check("t_dout_valid", 32'(bus.dout_valid), (c == 33) ? 32'd1 : 32'd0);
      if (c <= 32) check("t_coef_addr", 32'(bus.coef_addr), 32'(c - 1));
    end
    @(negedge clk);
    check("t_ready_cycle34", 32'(bus.din_ready), 32'd1);
    exp_q.push_back(16'h0000);
    @(posedge clk);
    @(negedge clk);
    bus.din_valid = 1'b0;
    check("t_second_accept", 32'(bus.busy), 32'd1);

    // Saturation: positive ramp into clip, then negative samples crossing zero
    set_rom(16'h7FFF, 16'h7FFF);
    for (int n = 1; n <= 32; n++) send(16'h7FFF, 1'b0, 1'b0, (n == 1) ? 16'h7FFE : 16'h7FFF);
    for (int n = 1; n <= 32; n++)
      send(16'h8000, 1'b0, 1'b0, (n < 16) ? 16'h7FFF : ((n == 16) ? 16'hFFF0 : 16'h8000));

    // Mode latch; flush and din_valid during MAC must be ignored
    set_rom(16'h4000, 16'h2000);
    accept(16'h7FFF, 1'b1, 1'b1, 16'h2000, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
      end
      if (c == 3) begin
        bus.din       = 16'h1234;
        bus.din_valid = 1'b1;
        bus.flush     = 1'b1;
      end
      if (c == 5) bus.mode_sel = 1'b0;
      if (c == 12) begin
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
      end
      check("m_coef_mode_hp", 32'(bus.coef_mode), 32'd1);
    end
    accept(16'h0000, 1'b0, 1'b0, 16'h4000, 1'b1);
    @(negedge clk);
    bus.din_valid = 1'b0;
    check("m_coef_mode_lp", 32'(bus.coef_mode), 32'd0);

    // Flush together with an accept clears the earlier samples
    set_rom(16'h4000, 16'h4000);
    send(16'h1000, 1'b0, 1'b1, 16'h0800);
    send(16'h1000, 1'b0, 1'b0, 16'h1000);
    send(16'h1000, 1'b0, 1'b0, 16'h1800);
    send(16'h7FFF, 1'b0, 1'b1, 16'h4000);

    // Reset in the middle of MAC: result dropped, delay line cleared
    accept(16'h7FFF, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("r_dout", 32'(bus.dout), 32'd0);
    check("r_din_ready", 32'(bus.din_ready), 32'd1);
    check("r_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    send(16'h7FFF, 1'b0, 1'b0, 16'h4000);

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
